// File: rtl/regfile_wr_arbiter_if.sv
// Write-port request/grant bundle between three requesters and the
// register-file write arbiter.
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    localparam int NUM_REQ = 3;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_dst;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         wr_dst;
    logic                      wr_ld;
    logic [DATA_W-1:0]         wr_data;
    logic                      bad_dst;

    // Requester side: drives requests, observes grant and write port.
    modport master (
        output req, req_dst, req_data,
        input  gnt, wr_dst, wr_ld, wr_data, bad_dst
    );

    // Arbiter side.
    modport slave (
        input  req, req_dst, req_data,
        output gnt, wr_dst, wr_ld, wr_data, bad_dst
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single write port of the 7-entry register
// file. All outputs are registered; index 7 has no register behind it, so
// such a request is granted but flagged with bad_dst instead of writing.
module regfile_wr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int NUM_REQ = 3;

    logic [1:0]         last;
    logic [NUM_REQ-1:0] eligible;
    logic               winFound;
    logic [1:0]         winIdx;
    logic [1:0]         cand;
    logic [ADDR_W-1:0]  dstArr  [NUM_REQ];
    logic [DATA_W-1:0]  dataArr [NUM_REQ];
    logic [ADDR_W-1:0]  winDst;
    logic [DATA_W-1:0]  winData;
    logic               badTarget;

    // Successor in the 0,1,2 ring.
    function automatic logic [1:0] nextIdx(input logic [1:0] cur);
        return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : gSlice
        assign dstArr[i]  = bus.req_dst[i*ADDR_W +: ADDR_W];
        assign dataArr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    // A requester holding gnt this cycle is still presenting the request
    // being consumed, so it sits out this edge.
    assign eligible = bus.req & ~bus.gnt;

    // Search last+1, last+2, last+3 and take the first eligible index.
    always_comb begin
        winFound = 1'b0;
        winIdx   = 2'd0;
        cand     = last;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = nextIdx(cand);
            if (!winFound && eligible[cand]) begin
                winFound = 1'b1;
                winIdx   = cand;
            end
        end
    end

    assign winDst    = dstArr[winIdx];
    assign winData   = dataArr[winIdx];
    assign badTarget = &winDst;

    // Register the winner onto the write port; idle cycles keep dst/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gnt     <= '0;
            bus.wr_ld   <= 1'b0;
            bus.bad_dst <= 1'b0;
            bus.wr_dst  <= '0;
            bus.wr_data <= '0;
            last        <= 2'd2;
        end else if (winFound) begin
            bus.gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winIdx;
            bus.wr_dst  <= winDst;
            bus.wr_data <= winData;
            bus.wr_ld   <= ~badTarget;
            bus.bad_dst <= badTarget;
            last        <= winIdx;
        end else begin
            bus.gnt     <= '0;
            bus.wr_ld   <= 1'b0;
            bus.bad_dst <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed stimulus pushes the
// expected output state per cycle, a negedge monitor pops and compares.
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nCmp = 0;
    int   nBad = 0;

    regfile_wr_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_wr_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
        logic       ld;
        logic       bad;
        logic [2:0] dst;
        logic [7:0] data;
    } exp_t;

    exp_t sbQ[$];

    // Register file model fed by the arbiter's write port.
    logic [7:0] rf [0:6];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 7; i++) rf[i] <= 8'h00;
        end else if (bus.wr_ld === 1'b1) begin
            rf[bus.wr_dst] <= bus.wr_data;
        end
    end

    // Monitor: compare the DUT outputs against the entry due this cycle.
    always @(negedge clk) begin
        if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
            exp_t e;
            e = sbQ.pop_front();
            nCmp++;
            if (bus.gnt !== e.gnt || bus.wr_ld !== e.ld || bus.bad_dst !== e.bad ||
                bus.wr_dst !== e.dst || bus.wr_data !== e.data) begin
                nBad++;
                $display("FAIL out@cyc%0d: got gnt=%b ld=%b bad=%b dst=%0d data=%h, want gnt=%b ld=%b bad=%b dst=%0d data=%h",
                         cyc, bus.gnt, bus.wr_ld, bus.bad_dst, bus.wr_dst, bus.wr_data,
                         e.gnt, e.ld, e.bad, e.dst, e.data);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Queue expectation for the state visible after the next edge, then advance.
    task automatic step(input logic [2:0] g, input logic ld, input logic bad,
                        input logic [2:0] d, input logic [7:0] dat);
        exp_t e;
        e.cyc = cyc + 1; e.gnt = g; e.ld = ld; e.bad = bad; e.dst = d; e.data = dat;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic [2:0] r,
                          input logic [2:0] d0, input logic [7:0] v0,
                          input logic [2:0] d1, input logic [7:0] v1,
                          input logic [2:0] d2, input logic [7:0] v2);
        bus.req      = r;
        bus.req_dst  = {d2, d1, d0};
        bus.req_data = {v2, v1, v0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        setReq(3'b000, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 8'h00);
        step(3'b000, 0, 0, 3'd0, 8'h00);
        step(3'b000, 0, 0, 3'd0, 8'h00);
        rst = 1'b0;

        // All three held: strict 0,1,2 rotation.
        setReq(3'b111, 3'd1, 8'hA1, 3'd2, 8'hB2, 3'd3, 8'hC3);
        step(3'b001, 1, 0, 3'd1, 8'hA1);
        step(3'b010, 1, 0, 3'd2, 8'hB2);
        step(3'b100, 1, 0, 3'd3, 8'hC3);
        step(3'b001, 1, 0, 3'd1, 8'hA1);
        step(3'b010, 1, 0, 3'd2, 8'hB2);
        step(3'b100, 1, 0, 3'd3, 8'hC3);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd3, 8'hC3);
        chk("r1", rf[1], 8'hA1);
        chk("r2", rf[2], 8'hB2);
        chk("r3", rf[3], 8'hC3);

        // Lone requester: granted every other cycle.
        setReq(3'b010, 3'd0, 8'h00, 3'd5, 8'h5A, 3'd0, 8'h00);
        step(3'b010, 1, 0, 3'd5, 8'h5A);
        step(3'b000, 0, 0, 3'd5, 8'h5A);
        step(3'b010, 1, 0, 3'd5, 8'h5A);
        step(3'b000, 0, 0, 3'd5, 8'h5A);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd5, 8'h5A);
        chk("r5", rf[5], 8'h5A);

        // Index 7: granted, flagged, no write.
        setReq(3'b100, 3'd0, 8'h00, 3'd0, 8'h00, 3'd7, 8'hFF);
        step(3'b100, 0, 1, 3'd7, 8'hFF);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd7, 8'hFF);
        chk("r0 after bad", rf[0], 8'h00);
        chk("r4 after bad", rf[4], 8'h00);
        chk("r6 after bad", rf[6], 8'h00);
        chk("r5 after bad", rf[5], 8'h5A);

        // Make 0 the last winner, then 0 and 2 arrive together: 2 first.
        setReq(3'b001, 3'd4, 8'h44, 3'd0, 8'h00, 3'd6, 8'h66);
        step(3'b001, 1, 0, 3'd4, 8'h44);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd4, 8'h44);
        bus.req = 3'b101;
        step(3'b100, 1, 0, 3'd6, 8'h66);
        step(3'b001, 1, 0, 3'd4, 8'h44);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd4, 8'h44);
        chk("r6", rf[6], 8'h66);
        chk("r4", rf[4], 8'h44);

        // Reset while a grant is visible; requester 0 wins first afterwards.
        setReq(3'b010, 3'd0, 8'h00, 3'd2, 8'h77, 3'd0, 8'h00);
        step(3'b010, 1, 0, 3'd2, 8'h77);
        rst = 1'b1;
        step(3'b000, 0, 0, 3'd0, 8'h00);
        rst = 1'b0;
        setReq(3'b011, 3'd1, 8'h11, 3'd2, 8'h77, 3'd0, 8'h00);
        step(3'b001, 1, 0, 3'd1, 8'h11);
        step(3'b010, 1, 0, 3'd2, 8'h77);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd2, 8'h77);
        chk("r1 after rst", rf[1], 8'h11);

        // Requester 1 loses, then withdraws: no write to its target.
        setReq(3'b111, 3'd3, 8'h33, 3'd6, 8'hE6, 3'd4, 8'hCC);
        step(3'b100, 1, 0, 3'd4, 8'hCC);
        bus.req = 3'b001;
        step(3'b001, 1, 0, 3'd3, 8'h33);
        bus.req = 3'b000;
        step(3'b000, 0, 0, 3'd3, 8'h33);
        step(3'b000, 0, 0, 3'd3, 8'h33);
        chk("r6 withdrawn", rf[6], 8'h66);
        chk("r4 new", rf[4], 8'hCC);
        chk("r3 new", rf[3], 8'h33);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 8'(sbQ.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
